// File: rtl/product_accumulator_if.sv
// Valid/ready bundle between the multiplier, the product accumulator and
// the writeback buffer. The master drives the input beat and OUT_READY.
interface product_accumulator_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,
  parameter int CNT_WIDTH = 8
);
  logic [2*WIDTH:0]     PROD;
  logic                 IN_VALID;
  logic                 IN_LAST;
  logic                 IN_READY;
  logic [ACC_WIDTH-1:0] OUT_DATA;
  logic [CNT_WIDTH-1:0] OUT_COUNT;
  logic                 OUT_OVF;
  logic                 OUT_VALID;
  logic                 OUT_READY;

  modport master (
    output PROD,
    output IN_VALID,
    output IN_LAST,
    output OUT_READY,
    input  IN_READY,
    input  OUT_DATA,
    input  OUT_COUNT,
    input  OUT_OVF,
    input  OUT_VALID
  );

  modport slave (
    input  PROD,
    input  IN_VALID,
    input  IN_LAST,
    input  OUT_READY,
    output IN_READY,
    output OUT_DATA,
    output OUT_COUNT,
    output OUT_OVF,
    output OUT_VALID
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums a group of unsigned products into a wide accumulator.
// Define PRODUCT_ACC_SATURATE_EN to clamp on carry-out instead of wrapping.
module product_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,
  parameter int CNT_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CLR,
  product_accumulator_if.slave  bus
);

  localparam int PW = 2*WIDTH+1;

  typedef enum logic {
    ACCUM,
    DONE
  } state_e;

  state_e               state_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 ovf_q;
  logic [ACC_WIDTH-1:0] data_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 oovf_q;
  logic                 ovalid_q;

  logic [ACC_WIDTH:0]   sum_d;
  logic                 carry_d;
  logic [ACC_WIDTH-1:0] acc_d;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 ovf_d;
  logic                 in_ready;
  logic                 accept;
  logic                 retire;

  assign in_ready = (state_q == ACCUM) |
                    ((state_q == DONE) & bus.OUT_READY);
  assign accept   = bus.IN_VALID & in_ready;
  assign retire   = (state_q == DONE) & bus.OUT_READY;

  // acc_q is already zero when a DONE-state beat starts the next group
  always_comb begin
    sum_d   = {1'b0, acc_q} +
              {{(ACC_WIDTH+1-PW){1'b0}}, bus.PROD};
    carry_d = sum_d[ACC_WIDTH];
`ifdef PRODUCT_ACC_SATURATE_EN
    acc_d   = carry_d ? {ACC_WIDTH{1'b1}}
                      : sum_d[ACC_WIDTH-1:0];
`else
    acc_d   = sum_d[ACC_WIDTH-1:0];
`endif
    cnt_d   = cnt_q + CNT_WIDTH'(1);
    ovf_d   = ovf_q | carry_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ACCUM;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      data_q   <= '0;
      count_q  <= '0;
      oovf_q   <= 1'b0;
      ovalid_q <= 1'b0;
    end else if (CLR) begin
      state_q  <= ACCUM;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      if (retire) begin
        ovalid_q <= 1'b0;
        state_q  <= ACCUM;
      end
      if (accept) begin
        if (bus.IN_LAST) begin
          data_q   <= acc_d;
          count_q  <= cnt_d;
          oovf_q   <= ovf_d;
          ovalid_q <= 1'b1;
          state_q  <= DONE;
          acc_q    <= '0;
          cnt_q    <= '0;
          ovf_q    <= 1'b0;
        end else begin
          acc_q    <= acc_d;
          cnt_q    <= cnt_d;
          ovf_q    <= ovf_d;
        end
      end
    end
  end

  assign bus.IN_READY  = in_ready;
  assign bus.OUT_DATA  = data_q;
  assign bus.OUT_COUNT = count_q;
  assign bus.OUT_OVF   = oovf_q;
  assign bus.OUT_VALID = ovalid_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench: default instance (ACC_WIDTH=24) and a narrow
// ACC_WIDTH=17 instance sharing the same stimulus.
module tb_product_accumulator;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  product_accumulator_if #(.WIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(8)) ifa ();
  product_accumulator_if #(.WIDTH(8), .ACC_WIDTH(17), .CNT_WIDTH(8)) ifb ();

  product_accumulator #(.WIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(8)) ua (
    .CLK(clk),
    .RST(rst),
    .CLR(clr),
    .bus(ifa.slave)
  );

  product_accumulator #(.WIDTH(8), .ACC_WIDTH(17), .CNT_WIDTH(8)) ub (
    .CLK(clk),
    .RST(rst),
    .CLR(clr),
    .bus(ifb.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [16:0] p,
                       input logic l, input logic ordy);
    ifa.IN_VALID  = v;
    ifa.PROD      = p;
    ifa.IN_LAST   = l;
    ifa.OUT_READY = ordy;
    ifb.IN_VALID  = v;
    ifb.PROD      = p;
    ifb.IN_LAST   = l;
    ifb.OUT_READY = ordy;
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    drive(1'b0, 17'd0, 1'b0, 1'b1);
    tick();
    tick();
    chk("rst_valid", 32'(ifa.OUT_VALID), 0);
    chk("rst_data", 32'(ifa.OUT_DATA), 0);
    chk("rst_count", 32'(ifa.OUT_COUNT), 0);
    chk("rst_ovf", 32'(ifa.OUT_OVF), 0);
    chk("rst_in_ready", 32'(ifa.IN_READY), 1);
    rst = 1'b0;

    // three maximal products
    drive(1'b1, 17'd65025, 1'b0, 1'b1);
    tick();
    chk("g1_no_early_valid", 32'(ifa.OUT_VALID), 0);
    tick();
    drive(1'b1, 17'd65025, 1'b1, 1'b1);
    tick();
    drive(1'b0, 17'd0, 1'b0, 1'b1);
    chk("g1_valid", 32'(ifa.OUT_VALID), 1);
    chk("g1_data", 32'(ifa.OUT_DATA), 195075);
    chk("g1_count", 32'(ifa.OUT_COUNT), 3);
    chk("g1_ovf", 32'(ifa.OUT_OVF), 0);
`ifdef PRODUCT_ACC_SATURATE_EN
    chk("g1n_data", 32'(ifb.OUT_DATA), 131071);
`else
    chk("g1n_data", 32'(ifb.OUT_DATA), 64003);
`endif
    chk("g1n_ovf", 32'(ifb.OUT_OVF), 1);
    chk("g1n_count", 32'(ifb.OUT_COUNT), 3);
    tick();
    chk("g1_retired", 32'(ifa.OUT_VALID), 0);
    chk("g1n_retired", 32'(ifb.OUT_VALID), 0);

    // held result under backpressure
    drive(1'b1, 17'd10, 1'b0, 1'b0);
    tick();
    drive(1'b1, 17'd20, 1'b1, 1'b0);
    tick();
    drive(1'b1, 17'd99, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(ifa.OUT_VALID), 1);
      chk("hold_data", 32'(ifa.OUT_DATA), 30);
      chk("hold_count", 32'(ifa.OUT_COUNT), 2);
      chk("hold_in_ready", 32'(ifa.IN_READY), 0);
      tick();
    end

    // retire and accept single-term group in the same cycle
    drive(1'b1, 17'd7, 1'b1, 1'b1);
    #1;
    chk("b2b_in_ready", 32'(ifa.IN_READY), 1);
    tick();
    drive(1'b0, 17'd0, 1'b0, 1'b1);
    chk("b2b_valid", 32'(ifa.OUT_VALID), 1);
    chk("b2b_data", 32'(ifa.OUT_DATA), 7);
    chk("b2b_count", 32'(ifa.OUT_COUNT), 1);
    chk("b2b_ovf", 32'(ifa.OUT_OVF), 0);
    tick();
    chk("b2b_retired", 32'(ifa.OUT_VALID), 0);

    // abort drops partial sum and the beat in the CLR cycle
    drive(1'b1, 17'd100, 1'b0, 1'b1);
    tick();
    drive(1'b1, 17'd200, 1'b0, 1'b1);
    tick();
    clr = 1'b1;
    drive(1'b1, 17'd5, 1'b1, 1'b1);
    tick();
    clr = 1'b0;
    drive(1'b0, 17'd0, 1'b0, 1'b1);
    chk("clr_valid", 32'(ifa.OUT_VALID), 0);
    chk("clr_in_ready", 32'(ifa.IN_READY), 1);
    drive(1'b1, 17'd3, 1'b1, 1'b0);
    tick();
    drive(1'b0, 17'd0, 1'b0, 1'b0);
    chk("clr_next_valid", 32'(ifa.OUT_VALID), 1);
    chk("clr_next_data", 32'(ifa.OUT_DATA), 3);
    chk("clr_next_count", 32'(ifa.OUT_COUNT), 1);

    // reset while holding a result
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_valid", 32'(ifa.OUT_VALID), 0);
    chk("rst2_data", 32'(ifa.OUT_DATA), 0);
    chk("rst2_count", 32'(ifa.OUT_COUNT), 0);
    chk("rst2_ovf", 32'(ifa.OUT_OVF), 0);
    chk("rst2_in_ready", 32'(ifa.IN_READY), 1);
    drive(1'b1, 17'd1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 17'd0, 1'b0, 1'b1);
    chk("rst2_next_valid", 32'(ifa.OUT_VALID), 1);
    chk("rst2_next_data", 32'(ifa.OUT_DATA), 1);
    chk("rst2_next_count", 32'(ifa.OUT_COUNT), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
